i2c_tx_fifo: RTL and testbench

//  Transmit FIFO between the APB slave front end and the I2C core.
//  - Write side: APB front end pushes one word per cycle (WR_ENA + WRITE_DATA_ON_TX).
//  - Read side: I2C core pops words with CORE_RD.
//  - Sends TX_EMPTY back to the front end, which routes it out as INT_TX.
//  - Adds FULL, fill level and sticky overflow/underflow status.

---
 rtl/i2c_tx_fifo_if.sv | 28 ++
 rtl/i2c_tx_fifo.sv | 67 ++++++
 tb/tb_i2c_tx_fifo.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2c_tx_fifo_if.sv
// Bus bundle between the APB front end / I2C core and the transmit FIFO.
interface i2c_tx_fifo_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
);
  logic              WR_ENA;
  logic [DWIDTH-1:0] WRITE_DATA_ON_TX;
  logic              CORE_RD;
  logic              CLR_STATUS;
  logic [DWIDTH-1:0] CORE_DATA;
  logic              TX_EMPTY;
  logic              TX_FULL;
  logic [AWIDTH:0]   LEVEL;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  // Front end / core side: drives push, pop and status clear
  modport master (
    output WR_ENA, WRITE_DATA_ON_TX, CORE_RD, CLR_STATUS,
    input  CORE_DATA, TX_EMPTY, TX_FULL, LEVEL, OVERFLOW, UNDERFLOW
  );

  // FIFO side
  modport slave (
    input  WR_ENA, WRITE_DATA_ON_TX, CORE_RD, CLR_STATUS,
    output CORE_DATA, TX_EMPTY, TX_FULL, LEVEL, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/i2c_tx_fifo.sv
// I2C transmit FIFO: first-word-fall-through, level-tracked full/empty,
// sticky overflow/underflow status.
module i2c_tx_fifo #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input logic           PCLK,
  input logic           PRESETn,
  i2c_tx_fifo_if.slave  bus
);
  localparam int              DEPTH   = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] ONE_L   = (AWIDTH+1)'(1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wptr, rptr;
  logic [AWIDTH:0]   level;
  logic              ovf, udf;
  logic              empty, full, rd_ok, wr_ok;

  // Full/empty come from the level count so pointer equality is never ambiguous
  assign empty = (level == '0);
  assign full  = (level == DEPTH_L);
  // A pop frees a slot in the same edge, so a push into a full FIFO is legal then
  assign rd_ok = bus.CORE_RD & ~empty;
  assign wr_ok = bus.WR_ENA & (~full | rd_ok);

  // Storage write; contents are never reset and only visible through the level
  always_ff @(posedge PCLK) begin
    if (wr_ok) mem[wptr] <= bus.WRITE_DATA_ON_TX;
  end

  // Pointers and level
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

  // Sticky fault flags; a new fault in the clearing cycle wins
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (bus.WR_ENA & ~wr_ok) | (ovf & ~bus.CLR_STATUS);
      udf <= (bus.CORE_RD & empty) | (udf & ~bus.CLR_STATUS);
    end
  end

  assign bus.CORE_DATA = empty ? '0 : mem[rptr];
  assign bus.TX_EMPTY  = empty;
  assign bus.TX_FULL   = full;
  assign bus.LEVEL     = level;
  assign bus.OVERFLOW  = ovf;
  assign bus.UNDERFLOW = udf;
endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Self-checking bench for i2c_tx_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_i2c_tx_fifo;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic PCLK;
  logic PRESETn;
  int   checks = 0;
  int   passed = 0;

  // reference model state
  logic [31:0] q[$];
  logic        m_ovf, m_udf;

  i2c_tx_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  i2c_tx_fifo #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] head;
    head = (q.size() != 0) ? q[0] : 32'h0;
    check({tag, ".level"}, 32'(bus.LEVEL), 32'(q.size()));
    check({tag, ".empty"}, 32'(bus.TX_EMPTY), 32'(q.size() == 0));
    check({tag, ".full"},  32'(bus.TX_FULL),  32'(q.size() == DEPTH));
    check({tag, ".data"},  bus.CORE_DATA, head);
    check({tag, ".ovf"},   32'(bus.OVERFLOW),  32'(m_ovf));
    check({tag, ".udf"},   32'(bus.UNDERFLOW), 32'(m_udf));
  endtask

  // One clock: drive inputs, advance model by the transfer rules, compare
  task automatic step(input logic wr, input logic [31:0] d, input logic rd, input logic clr,
                      input string tag);
    bit rd_ok, wr_ok;
    bus.WR_ENA = wr;
    bus.WRITE_DATA_ON_TX = d;
    bus.CORE_RD = rd;
    bus.CLR_STATUS = clr;
    rd_ok = rd && (q.size() > 0);
    wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
    m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
    m_udf = (rd && q.size() == 0) || (m_udf && !clr);
    if (rd_ok) void'(q.pop_front());
    if (wr_ok) q.push_back(d);
    @(posedge PCLK);
    #1;
    bus.WR_ENA = 1'b0;
    bus.CORE_RD = 1'b0;
    bus.CLR_STATUS = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus.WR_ENA = 1'b0;
    bus.WRITE_DATA_ON_TX = '0;
    bus.CORE_RD = 1'b0;
    bus.CLR_STATUS = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    PRESETn = 1'b0;
    #1;
    check_all("por");
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // 1. reset mid-burst: set a flag, load 5 words, then pull reset between edges
    step(1'b0, 0, 1'b1, 1'b0, "rst.udf");
    for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0, "rst.fill");
    #2 PRESETn = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check("rst.async_level", 32'(bus.LEVEL), 32'd0);
    check("rst.async_empty", 32'(bus.TX_EMPTY), 32'd1);
    check("rst.async_data",  bus.CORE_DATA, 32'd0);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0, "rst.release");

    // 2. fill to 16, overflow attempt, clear, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, "fill");
    check("fill.full", 32'(bus.TX_FULL), 32'd1);
    // 3. overflow
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, "ovf");
    check("ovf.flag", 32'(bus.OVERFLOW), 32'd1);
    check("ovf.level", 32'(bus.LEVEL), 32'd16);
    step(1'b0, 0, 1'b0, 1'b1, "ovf.clr");
    check("ovf.cleared", 32'(bus.OVERFLOW), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.order", bus.CORE_DATA, 32'hA0 + 32'(i));
      step(1'b0, 0, 1'b1, 1'b0, "drain");
    end
    check("drain.empty", 32'(bus.TX_EMPTY), 32'd1);

    // 4. simultaneous push+pop at full and at empty
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0, "refill");
    step(1'b1, 32'h1234_5678, 1'b1, 1'b0, "full.pp");
    check("full.pp.level", 32'(bus.LEVEL), 32'd16);
    check("full.pp.ovf", 32'(bus.OVERFLOW), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 1'b1, 1'b0, "drain2");
    step(1'b1, 32'hCAFE, 1'b1, 1'b0, "empty.pp");
    check("empty.pp.udf", 32'(bus.UNDERFLOW), 32'd1);
    check("empty.pp.level", 32'(bus.LEVEL), 32'd1);
    check("empty.pp.data", bus.CORE_DATA, 32'hCAFE);
    // clear and raise a new fault in the same cycle: fault wins
    step(1'b0, 0, 1'b0, 1'b1, "clr");
    step(1'b0, 0, 1'b1, 1'b0, "pop1");
    step(1'b0, 0, 1'b1, 1'b1, "clr.vs.udf");
    check("clr.vs.udf.flag", 32'(bus.UNDERFLOW), 32'd1);
    step(1'b0, 0, 1'b0, 1'b1, "clr2");

    // 5. wrap: hold level 3 through 40 push/pop pairs
    for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 1'b0, 1'b0, "wrap.pre");
    for (int i = 3; i < 43; i++) begin
      check("wrap.head", bus.CORE_DATA, 32'(i - 3));
      step(1'b1, 32'(i), 1'b1, 1'b0, "wrap");
      check("wrap.level", 32'(bus.LEVEL), 32'd3);
    end

    // random traffic, biased toward both boundaries in turn
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 150) % 2 == 0 ? 75 : 25;
      step(($urandom_range(99) < bias), $urandom, ($urandom_range(99) >= bias),
           ($urandom_range(15) == 0), "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
